// File: rtl/dcache_lookup_ctrl.sv
// rtl/dcache_lookup_ctrl.sv - direct-mapped read cache lookup/fill controller with external valid-bit RAM
// Optional macro HIT_COUNTER_EN adds saturating hit_count/miss_count outputs.
module dcache_lookup_ctrl #(
    parameter int INDEX     = 3,
    parameter int CACHESIZE = 8,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              flush,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [INDEX-1:0]  vr_addr,
    output logic              vr_write,
    output logic              vr_clear,
    input  logic              vr_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef HIT_COUNTER_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int TAG_W = ADDR_W - INDEX;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL,
        RESPOND,
        FLUSH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] req_addr;
    logic [INDEX-1:0]  req_index;
    logic [TAG_W-1:0]  req_tag;
    logic              hit;
    logic              fill_done;

    logic [TAG_W-1:0]  tag_mem  [CACHESIZE];
    logic [DATA_W-1:0] data_mem [CACHESIZE];

    assign req_index = req_addr[INDEX-1:0];
    assign req_tag   = req_addr[ADDR_W-1:INDEX];
    assign hit       = vr_valid && (tag_mem[req_index] == req_tag);
    assign fill_done = (state == FILL) && mem_ack;

    // Arrays carry no reset: a line is only trusted once the valid-bit RAM says so.
    always_ff @(posedge clk) begin
        if (!reset && fill_done) begin
            tag_mem[req_index]  <= req_tag;
            data_mem[req_index] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_addr  <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            vr_addr   <= '0;
            vr_write  <= 1'b0;
            vr_clear  <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
        end else begin
            cpu_ready <= 1'b0;
            vr_write  <= 1'b0;
            vr_clear  <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        vr_clear <= 1'b1;
                        state    <= FLUSH;
                    end else if (cpu_req) begin
                        req_addr <= cpu_addr;
                        vr_addr  <= cpu_addr[INDEX-1:0];
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        cpu_rdata <= data_mem[req_index];
                        state     <= RESPOND;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= req_addr;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        vr_write  <= 1'b1;
                        cpu_rdata <= mem_rdata;
                        state     <= RESPOND;
                    end
                end
                RESPOND: begin
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end
                FLUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef HIT_COUNTER_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_lookup_ctrl.sv
// tb/tb_dcache_lookup_ctrl.sv - self-checking bench for dcache_lookup_ctrl
// Valid-bit RAM and backing memory are modelled here; expected data comes from the backing store.
module tb_dcache_lookup_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req;
    logic [7:0] cpu_addr;
    logic       flush;
    logic       cpu_ready;
    logic [7:0] cpu_rdata;
    logic [2:0] vr_addr;
    logic       vr_write;
    logic       vr_clear;
    logic       vr_valid;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
`ifdef HIT_COUNTER_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    always #5 clk = ~clk;

    dcache_lookup_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .flush     (flush),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .vr_addr   (vr_addr),
        .vr_write  (vr_write),
        .vr_clear  (vr_clear),
        .vr_valid  (vr_valid),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef HIT_COUNTER_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    typedef struct {
        logic [7:0] addr;
        logic       exp_hit;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem_val   [256];
    logic       ram_valid [8];
    logic       m_valid   [8];
    logic [7:0] m_addr    [8];
    bit         mem_en;
    int         wait_cnt;
    int         exp_hits;
    int         exp_misses;

    // Valid-bit RAM: read on the falling edge, updated on the rising edge.
    always @(negedge clk) vr_valid <= ram_valid[vr_addr];
    always @(posedge clk) begin
        if (vr_clear) begin
            for (int i = 0; i < 8; i++) ram_valid[i] <= 1'b0;
        end else if (vr_write) begin
            ram_valid[vr_addr] <= 1'b1;
        end
    end

    // Backing memory with a random 0..3 cycle response delay.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        wait_cnt  = 1;
        forever begin
            @(posedge clk);
            #3;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_en && mem_req) begin
                if (wait_cnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_val[mem_addr];
                    wait_cnt  = $urandom_range(0, 3);
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_hit(input logic [7:0] a);
        return m_valid[a[2:0]] && (m_addr[a[2:0]] == a);
    endfunction

    task automatic do_read(input logic [7:0] a, input logic exp_hit);
        int         cyc;
        int         ack_cyc;
        logic       ack_pending;
        logic       saw_req;
        logic       addr_ok;
        logic       saw_wr;
        logic       done;
        logic [2:0] wr_idx;
        logic [2:0] idx;
        idx = a[2:0];
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = a;
        @(posedge clk);
        #1;
        cpu_req  = 1'b0;
        cpu_addr = 8'($urandom);
        cyc = 0; ack_cyc = -100; saw_req = 0; addr_ok = 1; saw_wr = 0; done = 0; wr_idx = '0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            ack_pending = mem_ack && mem_req;
            @(posedge clk);
            cyc++;
            if (ack_pending) ack_cyc = cyc;
            #1;
            if (mem_req) begin
                saw_req = 1;
                if (mem_addr !== a) addr_ok = 0;
            end
            if (vr_write) begin
                saw_wr = 1;
                wr_idx = vr_addr;
            end
            if (cpu_ready) done = 1;
        end
        chk("ready_seen", done, 1);
        chk("rdata", cpu_rdata, mem_val[a]);
        if (exp_hit) begin
            chk("hit_latency", cyc, 2);
            chk("hit_no_mem_req", saw_req, 0);
            exp_hits++;
        end else begin
            chk("miss_mem_req", saw_req, 1);
            chk("miss_mem_addr", addr_ok, 1);
            chk("miss_latency_after_ack", cyc - ack_cyc, 1);
            chk("miss_vr_write", saw_wr, 1);
            chk("miss_vr_addr", wr_idx, idx);
            m_valid[idx] = 1'b1;
            m_addr[idx]  = a;
            exp_misses++;
        end
        @(posedge clk);
        #1;
        chk("ready_one_cycle", cpu_ready, 0);
        chk("rdata_hold", cpu_rdata, mem_val[a]);
    endtask

    task automatic do_flush(input logic with_req);
        int   n_clr;
        logic busy;
        @(negedge clk);
        flush    = 1'b1;
        cpu_req  = with_req;
        cpu_addr = 8'h2B;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        cpu_req = 1'b0;
        n_clr   = int'(vr_clear);
        busy    = mem_req | cpu_ready;
        repeat (4) begin
            @(posedge clk);
            #1;
            n_clr += int'(vr_clear);
            busy  |= mem_req | cpu_ready;
        end
        chk("flush_single_clear", n_clr, 1);
        chk("flush_no_lookup", busy, 0);
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    vec_t       tbl1 [10];
    logic [7:0] ra;
    logic       busy;

    initial begin
        tbl1[0] = '{8'h2B, 1'b0};
        tbl1[1] = '{8'h2B, 1'b1};
        tbl1[2] = '{8'h4B, 1'b0};
        tbl1[3] = '{8'h4B, 1'b1};
        tbl1[4] = '{8'h2B, 1'b0};
        tbl1[5] = '{8'h13, 1'b0};
        tbl1[6] = '{8'h2B, 1'b0};
        tbl1[7] = '{8'h2B, 1'b1};
        tbl1[8] = '{8'hA0, 1'b0};
        tbl1[9] = '{8'hA0, 1'b1};

        for (int i = 0; i < 256; i++) mem_val[i] = 8'(i * 13 + 7);
        mem_val[8'h2B] = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            ram_valid[i] = 1'b0;
            m_valid[i]   = 1'b0;
            m_addr[i]    = 8'h00;
        end
        mem_en   = 1'b1;
        reset    = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = 8'h00;
        flush    = 1'b0;
        exp_hits = 0;
        exp_misses = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_vr_write", vr_write, 0);
        chk("rst_vr_clear", vr_clear, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_vr_addr", vr_addr, 0);
        chk("rst_mem_addr", mem_addr, 0);
`ifdef HIT_COUNTER_EN
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) do_read(tbl1[i].addr, tbl1[i].exp_hit);

        do_flush(1'b1);
        do_read(8'h2B, 1'b0);
        do_read(8'h2B, 1'b1);

        // Reset in the middle of a fill; the late ack must be ignored.
        mem_en = 1'b0;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 8'h66;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("fill_mem_req_high", mem_req, 1);
        do_reset();
        chk("rst_fill_mem_req", mem_req, 0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
        busy = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            busy |= vr_write | cpu_ready | mem_req;
        end
        chk("rst_fill_no_activity", busy, 0);
        mem_en = 1'b1;

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                do_flush(1'($urandom_range(0, 1)));
            end else begin
                ra = (8'($urandom_range(0, 3)) << 6) | 8'($urandom_range(0, 7));
                do_read(ra, model_hit(ra));
            end
        end

`ifdef HIT_COUNTER_EN
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_misses);
        do_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        do_flush(1'b0);
        do_read(8'h2B, 1'b0);
        do_read(8'h2B, 1'b1);
        do_read(8'h2B, 1'b1);
        do_read(8'h2B, 1'b1);
        do_read(8'h4B, 1'b0);
        chk("hit_count_3", hit_count, 3);
        chk("miss_count_2", miss_count, 2);
        @(negedge clk);
        dut.hit_count = 16'hFFFE;
        do_read(8'h4B, 1'b1);
        do_read(8'h4B, 1'b1);
        chk("hit_count_sat", hit_count, 16'hFFFF);
        do_flush(1'b0);
        chk("flush_keeps_count", hit_count, 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
